// File: rtl/sipo_word_receiver_pkg.sv
// Shared constants and helpers for the serial word receiver.
package sipo_word_receiver_pkg;

  // State encodings, kept as plain constants so they match the legacy encodings.
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  // Default word width.
  localparam int unsigned CID_WORD_W = 4;

  // Shift one serial bit into a word of width w (1..16).
  // With msb_first the bit enters at bit 0 and the word moves left.
  // Otherwise the bit enters at bit w-1 and the word moves right.
  // Bits at and above position w are always returned as zero.
  function automatic logic [15:0] shift_in(input logic [15:0] cur,
                                           input logic        b,
                                           input int unsigned w,
                                           input logic        msb_first);
    logic [15:0] mask;
    logic [15:0] cur_m;
    logic [15:0] r;
    mask  = 16'hFFFF >> (16 - w);
    cur_m = cur & mask;
    if (msb_first) begin
      r = (cur_m << 1) | {15'b0, b};
    end else begin
      r = (cur_m >> 1) | ({15'b0, b} << (w - 1));
    end
    return r & mask;
  endfunction

endpackage

// File: rtl/sipo_word_receiver_bit_counter.sv
// Counts the serial bits sampled in the current frame.
module bit_counter #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sipo_word_receiver.sv
// Serial-in/parallel-out word receiver: assembles WIDTH serial bits into a
// registered word and strobes valid for one cycle when a frame completes.
module sipo_word_receiver
  import sipo_word_receiver_pkg::*;
#(
  parameter int unsigned WIDTH     = CID_WORD_W,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             start,
  output logic [WIDTH-1:0] out,
  output logic             valid,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr, cnt_inc;

  bit_counter #(.W(CNT_W)) u_bit_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt)
  );

  // Frame sequencing; a new frame starts from an empty word so stale bits never leak in.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    out_d   = out_q;
    valid_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    shifted = WIDTH'(shift_in((state_q == ST_IDLE) ? 16'h0000 : 16'(shreg_q),
                              ser_in, WIDTH, MSB_FIRST));
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = shifted;
          if (WIDTH == 1) begin
            out_d   = shifted;
            valid_d = 1'b1;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        shreg_d = shifted;
        cnt_inc = 1'b1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          out_d   = shifted;
          valid_d = 1'b1;
          cnt_clr = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, shift register and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out   = out_q;
  assign valid = valid_q;
  assign busy  = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_sipo_word_receiver.sv
// Bench for sipo_word_receiver: MSB-first, LSB-first and single-bit instances
// share one stimulus stream and are compared every cycle against a frame model.
module tb_sipo_word_receiver;

  logic clk = 1'b0;
  logic rst, ser_in, start;

  logic [3:0] out_m, out_l;
  logic       valid_m, valid_l, busy_m, busy_l;
  logic [0:0] out_1;
  logic       valid_1, busy_1;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .start(start),
    .out(out_m), .valid(valid_m), .busy(busy_m));

  sipo_word_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .ser_in(ser_in), .start(start),
    .out(out_l), .valid(valid_l), .busy(busy_l));

  sipo_word_receiver #(.WIDTH(1), .MSB_FIRST(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .ser_in(ser_in), .start(start),
    .out(out_1), .valid(valid_1), .busy(busy_1));

  // Frame model: collect received bits into an array, build the word arithmetically.
  bit         m_active;
  int         m_n;
  bit         m_bits[4];
  logic [3:0] e_out_m, e_out_l;
  logic       e_valid4, e_busy4;
  logic [0:0] e_out_1;
  logic       e_valid_1;

  always @(posedge clk) begin
    if (rst) begin
      m_active  = 1'b0;
      m_n       = 0;
      e_out_m   = 4'h0;
      e_out_l   = 4'h0;
      e_valid4  = 1'b0;
      e_out_1   = 1'b0;
      e_valid_1 = 1'b0;
    end else begin
      e_valid4  = 1'b0;
      e_valid_1 = 1'b0;
      if (start) begin
        e_out_1   = ser_in;
        e_valid_1 = 1'b1;
      end
      if (m_active) begin
        m_bits[m_n] = ser_in;
        m_n++;
        if (m_n == 4) begin
          int wm, wl;
          wm = 0;
          wl = 0;
          for (int i = 0; i < 4; i++) begin
            wm += int'(m_bits[i]) * (2 ** (3 - i));
            wl += int'(m_bits[i]) * (2 ** i);
          end
          e_out_m  = 4'(wm);
          e_out_l  = 4'(wl);
          e_valid4 = 1'b1;
          m_active = 1'b0;
        end
      end else if (start) begin
        m_bits[0] = ser_in;
        m_n       = 1;
        m_active  = 1'b1;
      end
    end
    e_busy4 = m_active;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_msb",  int'(out_m),   int'(e_out_m));
      chk("out_lsb",  int'(out_l),   int'(e_out_l));
      chk("valid_m",  int'(valid_m), int'(e_valid4));
      chk("valid_l",  int'(valid_l), int'(e_valid4));
      chk("busy_m",   int'(busy_m),  int'(e_busy4));
      chk("busy_l",   int'(busy_l),  int'(e_busy4));
      chk("out_w1",   int'(out_1),   int'(e_out_1));
      chk("valid_w1", int'(valid_1), int'(e_valid_1));
      chk("busy_w1",  int'(busy_1),  0);
    end
  end

  // One clock cycle with the given inputs; returns 2 time units after the edge.
  task automatic cyc(input logic r, input logic s, input logic b);
    rst    = r;
    start  = s;
    ser_in = b;
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input logic [3:0] bits);
    cyc(1'b0, 1'b1, bits[3]);
    cyc(1'b0, 1'b0, bits[2]);
    cyc(1'b0, 1'b0, bits[1]);
    cyc(1'b0, 1'b0, bits[0]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ser_in = 1'b0;
    #2;
    // Test 1: reset then idle.
    cyc(1'b1, 1'b0, 1'b0);
    cmp_en = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1);
    chk("lit_reset_out", int'(out_m), 0);
    chk("lit_reset_busy", int'(busy_m), 0);

    // Tests 2/3: bits 1,0,1,1.
    cyc(1'b0, 1'b1, 1'b1);
    chk("lit_busy_T1", int'(busy_m), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("lit_msb_B", int'(out_m), 'hB);
    chk("lit_lsb_D", int'(out_l), 'hD);
    chk("lit_valid_T4", int'(valid_m), 1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_valid_T5", int'(valid_m), 0);
    chk("lit_hold_B", int'(out_m), 'hB);
    cyc(1'b0, 1'b0, 1'b1);

    // Test 4: back-to-back 0110 then 0101.
    frame(4'b0110);
    chk("lit_b2b_6", int'(out_m), 'h6);
    frame(4'b0101);
    chk("lit_b2b_5", int'(out_m), 'h5);
    chk("lit_b2b_lsb_A", int'(out_l), 'hA);
    cyc(1'b0, 1'b0, 1'b0);

    // Test 5: extra start inside a frame (1,0,1,1) is ignored.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("lit_extra_start_B", int'(out_m), 'hB);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_single_valid", int'(valid_m), 0);

    // Test 6: rst mid-frame after out=6, then clean 0011.
    frame(4'b0110);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("lit_rst_out", int'(out_m), 0);
    chk("lit_rst_busy", int'(busy_m), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lit_rst_novalid", int'(valid_m), 0);
    frame(4'b0011);
    chk("lit_clean_3", int'(out_m), 'h3);
    chk("lit_clean_lsb_C", int'(out_l), 'hC);

    // Start held high: single-bit instance pulses valid every cycle.
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lit_w1_out0", int'(out_1), 0);
    chk("lit_w1_valid", int'(valid_1), 1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
